// File: rtl/nvm_spi_reader.sv
// SPI mode-0 master that streams 16-bit little-endian words out of a serial NVM.
// Issues READ (0x03) + 16-bit address, then clocks data until word_count words are delivered.
module nvm_spi_reader #(
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [12:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        cs_n,
    output logic        sck,
    output logic        si,
    input  logic        so
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CMD   = 3'd2,
        ADDR  = 3'd3,
        DATA  = 3'd4,
        STALL = 3'd5,
        HOLD  = 3'd6
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);
    localparam logic [7:0] READ_CMD  = 8'h03;

    // Bytes arrive MSB first, first byte is the low half of the word.
    function automatic logic [15:0] swap_bytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [12:0] words_q, words_d;
    logic [23:0] tx_q, tx_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        si_q, si_d;
    logic [15:0] rx_s;
    logic        bit_end_s;
    logic        slot_free_s;

    // Next-state and output decode; sck_q doubles as the bit phase (1 = high half).
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        words_d   = words_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        si_d      = si_q;
        rx_s        = {shift_q[14:0], so};
        bit_end_s   = sck_q && (div_q == DIV_LAST);
        slot_free_s = !valid_q || data_ready;
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (start && (word_count == 13'd0)) begin
                    done_d = 1'b1;
                end else if (start) begin
                    tx_d    = {READ_CMD, start_addr};
                    words_d = word_count;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    si_d    = 1'b0;
                    div_d   = 8'd0;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                    si_d    = tx_q[23];
                    tx_d    = {tx_q[22:0], 1'b0};
                    state_d = CMD;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            CMD, ADDR, DATA: begin
                if (!bit_end_s) begin
                    if (div_q == DIV_LAST) begin
                        div_d = 8'd0;
                        sck_d = 1'b1;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end else begin
                    // End of a bit: falling sck, next si value launched here.
                    div_d = 8'd0;
                    sck_d = 1'b0;
                    bit_d = bit_q + 5'd1;
                    if (state_q != DATA) begin
                        si_d = tx_q[23];
                        tx_d = {tx_q[22:0], 1'b0};
                        if ((state_q == CMD) && (bit_q == 5'd7)) begin
                            bit_d   = 5'd0;
                            state_d = ADDR;
                        end else if ((state_q == ADDR) && (bit_q == 5'd15)) begin
                            bit_d   = 5'd0;
                            si_d    = 1'b0;
                            state_d = DATA;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        shift_d = rx_s;
                        if (bit_q != 5'd15) begin
                            state_d = DATA;
                        end else if (!slot_free_s) begin
                            bit_d   = 5'd0;
                            state_d = STALL;
                        end else begin
                            bit_d   = 5'd0;
                            data_d  = swap_bytes(rx_s);
                            valid_d = 1'b1;
                            words_d = words_q - 13'd1;
                            if (words_q == 13'd1) begin
                                cs_n_d  = 1'b1;
                                state_d = HOLD;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end
            end
            STALL: begin
                sck_d = 1'b0;
                if (data_ready) begin
                    data_d  = swap_bytes(shift_q);
                    valid_d = 1'b1;
                    words_d = words_q - 13'd1;
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                    if (words_q == 13'd1) begin
                        cs_n_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = STALL;
                end
            end
            HOLD: begin
                if (div_q != HOLD_LAST) begin
                    div_d = div_q + 8'd1;
                end else if (slot_free_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                si_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 5'd0;
            words_q <= 13'd0;
            tx_q    <= 24'd0;
            shift_q <= 16'd0;
            data_q  <= 16'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            si_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            words_q <= words_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            si_q    <= si_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign cs_n       = cs_n_q;
    assign sck        = sck_q;
    assign si         = si_q;
endmodule

// File: tb/tb_nvm_spi_reader.sv
// Bench for nvm_spi_reader: behavioural SPI NVM, word scoreboard, table-driven and corner-case runs.
module tb_nvm_spi_reader;
    localparam int CLK_DIV = 3;
    localparam int CS_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'd0;
    logic [12:0] word_count = 13'd0;
    logic        data_ready = 1'b0;
    logic        so = 1'b0;
    logic        busy, done, data_valid, cs_n, sck, si;
    logic [15:0] data_out;

    nvm_spi_reader #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .busy(busy), .done(done), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .cs_n(cs_n), .sck(sck),
        .si(si), .so(so)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held by the test

    logic [7:0] mem [0:65535];

    // SPI NVM model state
    int          bc = 0;
    logic [23:0] hdr = 24'd0;
    int          rise_total = 0;
    int          si_ones = 0;
    int          t0 = 0, t1 = 0;
    int          k;
    logic [15:0] ba;
    logic [7:0]  byt;

    // Monitor state
    int          cyc = 0;
    logic [15:0] got [$];
    int          done_cnt = 0, done_cyc = 0, cs_rise_cyc = 0, cs_fall_cnt = 0;
    int          busy_cnt = 0, busy_at_done = 1;
    logic        cs_prev = 1'b1;

    // Snapshots taken before each transaction
    int b_rise, b_si, b_got, b_done, b_fall, b_busy;

    // NVM: capture command/address on rising sck, count edges; cs_n falling restarts the frame.
    always @(posedge sck or negedge cs_n) begin
        if (!sck) begin
            bc = 0;
        end else if (!cs_n) begin
            if (bc == 0) t0 = cyc;
            if (bc == 1) t1 = cyc;
            if (bc < 24) hdr = {hdr[22:0], si};
            else if (si) si_ones++;
            bc++;
            rise_total++;
        end
    end

    // NVM: shift out memory bytes MSB first on falling sck, wrapping at 64 KiB.
    always @(negedge sck) begin
        if (!cs_n && bc >= 24) begin
            k   = bc - 24;
            ba  = hdr[15:0] + 16'(k / 8);
            byt = mem[ba];
            so  = byt[7 - (k % 8)];
        end
    end

    // Scoreboard and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (data_valid && data_ready) got.push_back(data_out);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
        end
        if (busy) busy_cnt++;
        if (cs_n && !cs_prev) cs_rise_cyc = cyc;
        if (!cs_n && cs_prev) cs_fall_cnt++;
        cs_prev = cs_n;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 1) data_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 0) data_ready = 1'b1;
    endtask

    task automatic snap();
        b_rise = rise_total; b_si = si_ones; b_got = got.size();
        b_done = done_cnt; b_fall = cs_fall_cnt; b_busy = busy_cnt;
    endtask

    task automatic start_txn(input logic [15:0] addr, input logic [12:0] wc);
        snap();
        start_addr = addr;
        word_count = wc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != b_done) break;
            if (poke && i == 20) begin
                start = 1'b1;
                start_addr = ~start_addr;
                word_count = 13'd7;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
    endtask

    // Expected words come straight from the memory image: word i = {mem[a+2i+1], mem[a+2i]}.
    task automatic check_txn(input logic [15:0] addr, input int wc, input int exp_edges, input bit strict);
        logic [15:0] a0, a1, ew;
        int act;
        chk("words_received", got.size() - b_got, wc);
        for (int i = 0; i < wc; i++) begin
            a0 = addr + 16'(2 * i);
            a1 = a0 + 16'd1;
            ew = {mem[a1], mem[a0]};
            act = (b_got + i < got.size()) ? int'(got[b_got + i]) : -1;
            chk($sformatf("word%0d", i), act, int'(ew));
        end
        chk("sck_rises", rise_total - b_rise, exp_edges);
        chk("cmd_byte", int'(hdr[23:16]), 8'h03);
        chk("addr_bits", int'(hdr[15:0]), int'(addr));
        chk("si_low_in_data", si_ones - b_si, 0);
        chk("sck_period", t1 - t0, 2 * CLK_DIV);
        chk("cs_falls", cs_fall_cnt - b_fall, 1);
        chk("done_pulses", done_cnt - b_done, 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("busy_seen", int'(busy_cnt > b_busy), 1);
        if (strict) chk("done_delay", done_cyc - cs_rise_cyc, CS_HOLD);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [12:0] wc;
        int          mode;
        bit          poke;
        int          exp_edges;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] ra;
        logic [12:0] rw;
        logic [15:0] w0;
        int d0;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34;
        mem[1] = 8'h12;

        vecs[0] = '{16'h0000, 13'd1, 0, 1'b0, 40};
        vecs[1] = '{16'h1FFE, 13'd2, 0, 1'b0, 56};
        vecs[2] = '{16'hFFFE, 13'd3, 0, 1'b0, 72};
        vecs[3] = '{16'h0100, 13'd5, 1, 1'b0, 104};
        for (int i = 4; i < 8; i++) begin
            ra = 16'($urandom);
            rw = 13'($urandom_range(1, 6));
            vecs[i] = '{ra, rw, 1, (i == 4), 24 + 16 * int'(rw)};
        end

        // Reset state
        repeat (3) tick();
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_sck", int'(sck), 0);
        chk("rst_si", int'(si), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_data", int'(data_out), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Zero-length request
        start_txn(16'h0055, 13'd0);
        chk("zero_done_next", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        tick();
        chk("zero_done_single", int'(done), 0);
        repeat (3) tick();
        chk("zero_done_count", done_cnt - b_done, 1);
        chk("zero_no_cs", cs_fall_cnt - b_fall, 0);
        chk("zero_no_sck", rise_total - b_rise, 0);

        // Table-driven transactions
        for (int v = 0; v < 8; v++) begin
            ready_mode = vecs[v].mode;
            data_ready = 1'b1;
            start_txn(vecs[v].addr, vecs[v].wc);
            wait_done(vecs[v].exp_edges * 2 * CLK_DIV * 4 + 200, vecs[v].poke);
            check_txn(vecs[v].addr, int'(vecs[v].wc), vecs[v].exp_edges, vecs[v].mode == 0);
            if (v == 0) chk("word_1234", (got.size() > b_got) ? int'(got[b_got]) : -1, 16'h1234);
        end

        // Backpressure: hold data_ready low long enough for the next word to stall
        ready_mode = 2;
        data_ready = 1'b0;
        start_txn(16'h0420, 13'd3);
        for (int i = 0; i < 2000 && !data_valid; i++) tick();
        chk("stall_first_valid", int'(data_valid), 1);
        repeat (200) tick();
        w0 = {mem[16'h0421], mem[16'h0420]};
        chk("stall_sck_low", int'(sck), 0);
        chk("stall_rises", rise_total - b_rise, 56);
        chk("stall_valid_held", int'(data_valid), 1);
        chk("stall_word0", int'(data_out), int'(w0));
        chk("stall_no_handshake", got.size() - b_got, 0);
        ready_mode = 0;
        data_ready = 1'b1;
        wait_done(2000, 1'b0);
        check_txn(16'h0420, 3, 72, 1'b0);

        // Asynchronous reset in the middle of the data phase
        ra = 16'($urandom);
        start_txn(ra, 13'd4);
        for (int i = 0; i < 2000 && (rise_total - b_rise) < 40; i++) tick();
        chk("abort_reached_40", int'((rise_total - b_rise) >= 40), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_cs_n", int'(cs_n), 1);
        chk("abort_sck", int'(sck), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(data_valid), 0);
        d0 = done_cnt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);

        ra = 16'($urandom);
        start_txn(ra, 13'd2);
        wait_done(2000, 1'b0);
        check_txn(ra, 2, 56, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
